// File: rtl/display_scanner.sv
// rtl/display_scanner.sv - 4-digit multiplexed 7-segment scanner with frame snapshot, zero blanking and error blink
//
// Ports:
//   clock        system clock, rising edge
//   reset        synchronous, active-high
//   enable       scan enable; when low the scan freezes and all anodes are off
//   value        four BCD nibbles, [15:12] is the leftmost digit (digit 3)
//   error        fault level, latched until error_clear
//   error_clear  clears the latched fault when error is low
//   blink        blink the normal display
//   digit_code   nibble to the shared segment decoder
//   anode_n      active-low digit enables, bit i drives digit i
//   frame_done   one-cycle pulse at each frame end
module display_scanner #(
    parameter int          SCAN_DIV     = 1000,
    parameter int          DEAD_CYCLES  = 2,
    parameter int          BLINK_FRAMES = 64,
    parameter logic [3:0]  ERR_D3       = 4'hC,
    parameter logic [3:0]  ERR_D2       = 4'hE,
    parameter logic [3:0]  ERR_D1       = 4'hE,
    parameter logic [3:0]  ERR_D0       = 4'hF
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        enable,
    input  logic [15:0] value,
    input  logic        error,
    input  logic        error_clear,
    input  logic        blink,
    output logic [3:0]  digit_code,
    output logic [3:0]  anode_n,
    output logic        frame_done
);

    localparam int PW = $clog2(SCAN_DIV);
    localparam int BW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
    localparam logic [PW-1:0] PRESC_LAST = PW'(SCAN_DIV - 1);
    localparam logic [PW-1:0] DEAD_P     = PW'(DEAD_CYCLES);
    localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_FRAMES - 1);

    logic [PW-1:0] prescaler;
    logic [1:0]    index;
    logic [15:0]   snapshot;
    logic          err_latched;
    logic [BW-1:0] blink_cnt;
    logic          visible;

    logic          slot_end;
    logic          frame_end;
    logic          err_next;
    logic          blink_active;
    logic [3:0]    supp;
    logic [3:0]    nibble;
    logic [3:0]    err_code;
    logic          lit;

    always_comb begin
        slot_end  = enable && (prescaler == PRESC_LAST);
        frame_end = slot_end && (index == 2'd3);

        // error wins over a simultaneous clear
        err_next = error | (err_latched & ~error_clear);

        // Blink activity follows the next latch state so that a clear restores
        // visibility on the same edge the latch drops, giving two-cycle response.
        blink_active = blink | err_next;

        // Leading-zero chain: a digit blanks only if everything left of it blanked.
        supp[3] = (snapshot[15:12] == 4'h0);
        supp[2] = supp[3] && (snapshot[11:8] == 4'h0);
        supp[1] = supp[2] && (snapshot[7:4] == 4'h0);
        supp[0] = 1'b0;

        nibble   = 4'h0;
        err_code = ERR_D0;
        case (index)
            2'd0: begin nibble = snapshot[3:0];   err_code = ERR_D0; end
            2'd1: begin nibble = snapshot[7:4];   err_code = ERR_D1; end
            2'd2: begin nibble = snapshot[11:8];  err_code = ERR_D2; end
            default: begin nibble = snapshot[15:12]; err_code = ERR_D3; end
        endcase

        // Dead cycles at the start of each slot keep the previous digit's
        // segments from ghosting onto the newly selected anode.
        lit = enable && (prescaler >= DEAD_P) && visible
              && (err_latched || !supp[index]);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            prescaler   <= '0;
            index       <= 2'd0;
            snapshot    <= 16'h0000;
            err_latched <= 1'b0;
            blink_cnt   <= '0;
            visible     <= 1'b1;
            anode_n     <= 4'b1111;
            digit_code  <= 4'h0;
            frame_done  <= 1'b0;
        end else begin
            err_latched <= err_next;

            if (enable) begin
                prescaler <= slot_end ? '0 : prescaler + PW'(1);
                if (slot_end) begin
                    index <= index + 2'd1;
                end
            end

            frame_done <= frame_end;
            if (frame_end) begin
                snapshot <= value;
            end

            if (!blink_active) begin
                blink_cnt <= '0;
                visible   <= 1'b1;
            end else if (frame_end) begin
                if (blink_cnt == BLINK_LAST) begin
                    blink_cnt <= '0;
                    visible   <= ~visible;
                end else begin
                    blink_cnt <= blink_cnt + BW'(1);
                end
            end

            if (enable) begin
                digit_code <= err_latched ? err_code : nibble;
            end

            anode_n <= 4'b1111;
            if (lit) begin
                anode_n[index] <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_display_scanner.sv
// tb/tb_display_scanner.sv - directed table-driven bench for display_scanner
module tb_display_scanner;

    logic        clock = 1'b0;
    logic        reset;
    logic        enable;
    logic [15:0] value;
    logic        error;
    logic        error_clear;
    logic        blink;
    logic [3:0]  digit_code;
    logic [3:0]  anode_n;
    logic        frame_done;

    int checks = 0;
    int fails  = 0;

    localparam logic [15:0] ERR_CODES = 16'hCEEF;

    typedef struct packed {
        logic [15:0] value;
        logic [15:0] codes;
        logic [3:0]  lit;
    } vec_t;

    vec_t vecs [8];

    always #5 clock = ~clock;

    display_scanner #(
        .SCAN_DIV(4),
        .DEAD_CYCLES(1),
        .BLINK_FRAMES(2)
    ) dut (
        .clock(clock),
        .reset(reset),
        .enable(enable),
        .value(value),
        .error(error),
        .error_clear(error_clear),
        .blink(blink),
        .digit_code(digit_code),
        .anode_n(anode_n),
        .frame_done(frame_done)
    );

    task automatic tick;
        @(posedge clock);
        #1;
    endtask

    task automatic check4(input string name, input logic [3:0] act, input logic [3:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // One cycle of slot s, prescaler phase c: cycle 0 is the dead cycle.
    task automatic check_cycle(input int s, input int c, input logic [15:0] codes,
                               input logic [3:0] lit, input string tag);
        logic [3:0] ea;
        tick;
        ea = 4'b1111;
        if (c != 0 && lit[s]) ea[s] = 1'b0;
        check4($sformatf("%s s%0d c%0d anode_n", tag, s, c), anode_n, ea);
        check4($sformatf("%s s%0d c%0d digit_code", tag, s, c), digit_code, codes[4*s +: 4]);
        check4($sformatf("%s s%0d c%0d frame_done", tag, s, c), {3'b000, frame_done},
               4'((s == 3) && (c == 3)));
    endtask

    task automatic check_range(input int first, input int last, input logic [15:0] codes,
                               input logic [3:0] lit, input string tag);
        for (int k = first; k <= last; k++) begin
            check_cycle(k / 4, k % 4, codes, lit, tag);
        end
    endtask

    task automatic wait_frame(input string tag);
        int n;
        n = 0;
        do begin
            tick;
            n++;
        end while (!frame_done && n < 40);
        checks++;
        if (!frame_done) begin
            fails++;
            $display("FAIL %s: frame_done not seen within %0d cycles", tag, n);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = '{16'h1234, 16'h1234, 4'b1111};
        vecs[1] = '{16'h0070, 16'h0070, 4'b0011};
        vecs[2] = '{16'h0000, 16'h0000, 4'b0001};
        vecs[3] = '{16'h0A00, 16'h0A00, 4'b0111};
        vecs[4] = '{16'h0100, 16'h0100, 4'b0111};
        vecs[5] = '{16'h1000, 16'h1000, 4'b1111};
        vecs[6] = '{16'h000F, 16'h000F, 4'b0001};
        vecs[7] = '{16'h9005, 16'h9005, 4'b1111};

        reset       = 1'b1;
        enable      = 1'b1;
        value       = 16'h1234;
        error       = 1'b0;
        error_clear = 1'b0;
        blink       = 1'b0;
        tick;
        tick;
        check4("reset anode_n", anode_n, 4'b1111);
        check4("reset digit_code", digit_code, 4'h0);
        check4("reset frame_done", {3'b000, frame_done}, 4'h0);

        // first frame shows the zero snapshot, then the captured 1234
        reset = 1'b0;
        check_range(0, 15, 16'h0000, 4'b0001, "frame1");
        check_range(0, 15, 16'h1234, 4'b1111, "frame2");

        for (int v = 0; v < 8; v++) begin
            value = vecs[v].value;
            wait_frame($sformatf("vec%0d sync", v));
            check_range(0, 15, vecs[v].codes, vecs[v].lit, $sformatf("vec%0d", v));
        end

        // no tearing: mid-frame change only shows after the next frame end
        value = 16'h1234;
        wait_frame("tear sync");
        check_range(0, 4, 16'h1234, 4'b1111, "tear pre");
        value = 16'h5678;
        check_range(5, 15, 16'h1234, 4'b1111, "tear post");
        check_range(0, 15, 16'h5678, 4'b1111, "tear next");

        // one-cycle error pulse: 2 frames lit, 2 dark, repeating
        error = 1'b1;
        tick;
        check4("err entry anode_n", anode_n, 4'b1111);
        error = 1'b0;
        check_range(1, 15, ERR_CODES, 4'b1111, "errA");
        check_range(0, 15, ERR_CODES, 4'b1111, "errB");
        check_range(0, 15, ERR_CODES, 4'b0000, "errC");
        check_range(0, 15, ERR_CODES, 4'b0000, "errD");
        check_range(0, 15, ERR_CODES, 4'b1111, "errE");

        // clear with error still high keeps the latch
        error       = 1'b1;
        error_clear = 1'b1;
        check_cycle(0, 0, ERR_CODES, 4'b1111, "errF");
        error       = 1'b0;
        error_clear = 1'b0;
        check_range(1, 15, ERR_CODES, 4'b1111, "errF");
        check_range(0, 15, ERR_CODES, 4'b0000, "errG");

        // clear alone during a dark frame: normal and visible two cycles later
        error_clear = 1'b1;
        check_cycle(0, 0, ERR_CODES, 4'b0000, "clr");
        error_clear = 1'b0;
        check_range(1, 15, 16'h5678, 4'b1111, "clr");

        // enable low mid-slot freezes the scan and blanks the anodes
        check_range(0, 5, 16'h5678, 4'b1111, "en pre");
        enable = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick;
            check4($sformatf("en off %0d anode_n", i), anode_n, 4'b1111);
            check4($sformatf("en off %0d digit_code", i), digit_code, 4'h7);
            check4($sformatf("en off %0d frame_done", i), {3'b000, frame_done}, 4'h0);
        end
        enable = 1'b1;
        check_range(6, 15, 16'h5678, 4'b1111, "en post");

        // reset on the cycle that would otherwise raise frame_done
        check_range(0, 14, 16'h5678, 4'b1111, "rst pre");
        value = 16'h0008;
        reset = 1'b1;
        tick;
        check4("midrst anode_n", anode_n, 4'b1111);
        check4("midrst digit_code", digit_code, 4'h0);
        check4("midrst frame_done", {3'b000, frame_done}, 4'h0);
        tick;
        reset = 1'b0;
        check_range(0, 15, 16'h0000, 4'b0001, "rst frame");

        // blink: frames 0-1 lit, 2-3 dark; drop blink while dark
        blink = 1'b1;
        check_range(0, 15, 16'h0008, 4'b0001, "blk0");
        check_range(0, 15, 16'h0008, 4'b0001, "blk1");
        check_range(0, 15, 16'h0008, 4'b0000, "blk2");
        check_cycle(0, 0, 16'h0008, 4'b0000, "blk3");
        blink = 1'b0;
        check_cycle(0, 1, 16'h0008, 4'b0000, "blk3");
        check_range(2, 15, 16'h0008, 4'b0001, "blk3");

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule

// File: doc/display_scanner.md
Name: display_scanner

Overview:
- Time-multiplexes one shared 4-bit 7-segment decoder across a 4-digit common-anode display for the irrigation timer.
- Sequences digit select and per-digit code, snapshots the BCD countdown once per frame, and suppresses leading zeros.
- Shows a sticky "Erro" pattern on fault, with optional blinking.
- Sits between the timer/countdown logic and the display decoder; decoder segments drive all digits in parallel, gated by anode_n.

Parameters:
- SCAN_DIV, 1000: clock cycles per digit slot; legal range ≥2.
- DEAD_CYCLES, 2: anti-ghosting cycles at the start of each slot with all anodes off; legal range 0..SCAN_DIV-1.
- BLINK_FRAMES, 64: frames per blink half-period; legal range ≥1.
- ERR_D3 / ERR_D2 / ERR_D1 / ERR_D0, 4'hC / 4'hE / 4'hE / 4'hF: decoder codes for "E","r","r","o"; digit 3 is leftmost.

Ports:
- clock, in, 1: single system clock, rising edge.
- reset, in, 1: synchronous, active-high.
- enable, in, 1: scan enable.
- value, in, 16: four BCD nibbles; [15:12] is digit 3, [3:0] is digit 0.
- error, in, 1: fault indication; level-sensitive, latched.
- error_clear, in, 1: clears the latched error.
- blink, in, 1: blink the normal display.
- digit_code, out, 4: code to the display decoder.
- anode_n, out, 4: active-low digit enables; bit i drives digit i.
- frame_done, out, 1: one-cycle pulse at each frame end.

Behaviour:
- Interface: one clock; reset is synchronous and active-high (ports clock, reset). All outputs are registered.
- Reset values:
  - prescaler=0, index=0, snapshot=16'h0000, err_latched=0, blink_cnt=0, visible=1.
  - anode_n=4'b1111, digit_code=4'h0, frame_done=0.
  - Reset mid-operation returns everything to these values on the next edge.
- Prescaler:
  - When enable=1, counts 0..SCAN_DIV-1.
  - On wrap to 0, index advances mod 4 (0→1→2→3→0).
  - When enable=0, prescaler, index and blink_cnt hold; anode_n is forced to 1111; digit_code holds.
- Frame end: the cycle where the prescaler wraps with index==3 and enable=1. On that edge:
  - snapshot<=value;
  - frame_done<=1 for exactly one cycle;
  - the blink counter steps.
  - value changes at any other time do not affect the display until the next frame end (no tearing).
- Output registration (one-cycle latency from current state):
  - digit_code<=selected nibble for index. Normal mode selects from snapshot; error mode uses ERR_D[index].
  - anode_n[i]<=0 iff enable && index==i && prescaler≥DEAD_CYCLES && visible && !suppressed(i); otherwise 1.
- Leading-zero suppression (normal mode only):
  - Digit 3 is suppressed if snapshot[15:12]==0.
  - Digit 2 is suppressed if digit 3 is suppressed and [11:8]==0.
  - Digit 1 is suppressed if digit 2 is suppressed and [7:4]==0.
  - Digit 0 is never suppressed.
  - Nibbles >9 pass through unmodified and count as non-zero.
- Error latch:
  - err_latched<=1 on any cycle with error=1, independent of enable.
  - err_latched<=0 on error_clear=1 with error=0.
  - If error and error_clear are both high, the latch stays set.
  - In error mode: no suppression; display always blinks; snapshot keeps updating.
- Blink (active when blink=1 or err_latched=1):
  - blink_cnt counts frame ends 0..BLINK_FRAMES-1; on wrap, visible toggles.
  - When both are 0: blink_cnt<=0 and visible<=1 on the next edge.
  - Entering blink starts from visible=1 with a fresh count.
- Mode changes on error/blink/error_clear take effect at output two cycles after the input edge (latch, then output register).

Test Plan (SCAN_DIV=4, DEAD_CYCLES=1, BLINK_FRAMES=2):
1. Reset, enable=1, value=16'h1234 → frame 1 shows 0000 with suppression (only digit 0, code 0). From the cycle after the first frame_done:
   - anode_n 1110/code 4, 1101/3, 1011/2, 0111/1;
   - each anode low 3 cycles, then 1 all-high cycle;
   - frame_done every 16 cycles.
2. value=16'h0070 → digits 3 and 2 never enabled; digit 1 shows 7; digit 0 shows 0. value=16'h0000 → only digit 0 lights, code 0.
3. value changes 16'h1234→16'h5678 mid-frame (cycle 5) → remainder of that frame shows 1234; next frame shows 5678.
4. Error behaviour:
   - 1-cycle error pulse → codes C,E,E,F on digits 3..0, all four shown; 2 frames lit, 2 frames dark, repeating.
   - error_clear with error=1 → still in error mode.
   - error_clear alone → normal digits and visible within 2 cycles.
5. enable=0 for 10 cycles mid-slot → anode_n=1111; prescaler and index frozen; resumes the same slot on re-enable. reset mid-frame → anode_n=1111, digit_code=0, frame_done=0 next cycle.
6. blink=1, value=16'h0008 → digit 0 lit in frames 0–1, dark in frames 2–3. Drop blink while dark → anodes resume at the next eligible slot cycle.
